// File: rtl/demux_stream_pkg.sv
// Shared defaults, parameter checks and helpers for the registered stream demultiplexer.
package demux_stream_pkg;

    localparam int unsigned DEFAULT_NUM_CH = 4;
    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_SEL_W  = 2;
    localparam int unsigned DEFAULT_CNT_W  = 16;
    localparam int unsigned MAX_CNT_W      = 64;

    // Drop counter saturates at all-ones; each instance slices this to its own CNT_W.
    localparam logic [MAX_CNT_W-1:0] DROP_CNT_SAT = '1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    function automatic bit sel_width_ok(input int unsigned sel_w, input int unsigned num_ch);
        return sel_w >= clog2(num_ch);
    endfunction

endpackage

// File: rtl/demux_out_reg.sv
// One-deep valid/ready output register; free when empty or draining this cycle.
module demux_out_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              free
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign free      = !valid_q || ready_in;
    assign valid_out = valid_q;
    assign data_out  = data_q;

    // A reload wins over a drain, so drain+reload keeps valid set with fresh data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
        end else if (ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Registered 1:NUM_CH stream demultiplexer with per-channel valid/ready,
// illegal-select discard, a registered drop pulse and a saturating drop counter.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned SEL_W  = DEFAULT_SEL_W,
    parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [DATA_W-1:0]        in_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     drop,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_SAT = DROP_CNT_SAT[CNT_W-1:0];

    if (!sel_width_ok(SEL_W, NUM_CH) || NUM_CH < 2 || NUM_CH > 16) begin : g_param_check
        $error("demux_stream: SEL_W too narrow for NUM_CH or NUM_CH out of range");
    end

    logic [NUM_CH-1:0] ch_free;
    logic [NUM_CH-1:0] load;
    logic              sel_legal;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    assign sel_legal = 32'(in_sel) < NUM_CH;

    // Illegal selects fall through with in_ready=1 so the beat is swallowed.
    always_comb begin
        load     = '0;
        in_ready = 1'b1;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (32'(in_sel) == k) begin
                in_ready = ch_free[k];
                load[k]  = in_valid && ch_free[k];
            end
        end
    end

    assign drop_d = in_valid && !sel_legal;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && drop_cnt_q != CNT_SAT) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop     = drop_q;
    assign drop_cnt = drop_cnt_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        demux_out_reg #(
            .DATA_W(DATA_W)
        ) u_reg (
            .clk      (clk),
            .rst      (rst),
            .load     (load[ch]),
            .data_in  (in_data),
            .ready_in (out_ready[ch]),
            .valid_out(out_valid[ch]),
            .data_out (out_data[ch*DATA_W +: DATA_W]),
            .free     (ch_free[ch])
        );
    end

endmodule
